// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - Four-requester round-robin arbiter with registered one-hot and encoded grant
//
// Purpose : shares one resource between 4 requesters. Rotating priority starts
//           just after the most recent winner. A grant is held while its request
//           stays high. When a grant is released with others pending, a new winner
//           is chosen at the same edge, so there is no idle cycle between grants.
// Macro   : ARB_TIMEOUT_EN - when defined, a holder is forced off after MAX_HOLD
//           consecutive grant cycles if another requester is waiting.
// Ports   : clk       - rising-edge clock
//           rst       - synchronous active-high reset
//           req[3:0]  - level-sensitive requests, bit i = requester i
//           gnt[3:0]  - registered one-hot grant, 0000 when idle
//           gnt_idx   - registered encoded winner, valid when gnt_valid=1
//           gnt_valid - registered, high while any gnt bit is high

module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    // Reject out-of-range hold limits at elaboration time.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [1:0] last_idx;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
`endif

    // Rotating search: first set bit at or after last+1, wrapping around.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [3:0] cand_req;
    logic [2:0] win;
    logic       hold_req;
    logic       others;
    logic       force_rel;

    always_comb begin
        // The current holder never takes part in a re-arbitration: either its
        // request has dropped or it is being forced off. In IDLE gnt is zero.
        cand_req = req & ~gnt;
        win      = pick(cand_req, last_idx);
        hold_req = (state == GRANT) && req[gnt_idx];
        others   = |cand_req;
`ifdef ARB_TIMEOUT_EN
        force_rel = hold_req && others && (hold_cnt == HOLD_LAST);
`else
        force_rel = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            last_idx  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
        end else begin
            if (hold_req && !force_rel) begin
                // Keep the grant as is.
`ifdef ARB_TIMEOUT_EN
                // Limit reached with nobody waiting: restart the hold window.
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt <= 8'd0;
                end else begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
`endif
            end else if (win[2]) begin
                state     <= GRANT;
                gnt       <= 4'b0001 << win[1:0];
                gnt_idx   <= win[1:0];
                gnt_valid <= 1'b1;
                last_idx  <= win[1:0];
`ifdef ARB_TIMEOUT_EN
                hold_cnt  <= 8'd0;
`endif
            end else begin
                state     <= IDLE;
                gnt       <= 4'b0000;
                gnt_idx   <= 2'b00;
                gnt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - Self-checking bench for rr_arbiter4 with a behavioural reference model

module tb_rr_arbiter4;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int vectors;
    int miscompares;
    bit check_en;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who holds the resource (-1 = nobody), who won last,
    // and how many cycles the holder has had so far (minus one).
    int m_holder;
    int m_last;
    int m_cnt;

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_holder = -1;
            m_last   = 3;
            m_cnt    = 0;
        end else begin
            bit keep;
            bit waiting;
            waiting = 1'b0;
            for (int i = 0; i < 4; i++)
                if (req[i] && i != m_holder) waiting = 1'b1;
            keep = (m_holder >= 0) && req[m_holder] &&
                   !(TIMEOUT && waiting && m_cnt == MAX_HOLD - 1);
            if (keep) begin
                if (TIMEOUT && m_cnt == MAX_HOLD - 1) m_cnt = 0;
                else m_cnt = m_cnt + 1;
            end else begin
                int w;
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last + k) % 4;
                    if (w < 0 && req[c] && c != m_holder) w = c;
                end
                m_holder = w;
                m_cnt    = 0;
                if (w >= 0) m_last = w;
            end
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (check_en) begin
            logic [3:0] e_gnt;
            e_gnt = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
            vectors++;
            if (gnt !== e_gnt || gnt_valid !== (m_holder >= 0) ||
                (m_holder >= 0 && gnt_idx !== 2'(m_holder)) ||
                (m_holder < 0 && gnt_idx !== 2'b00)) begin
                miscompares++;
                $display("FAIL model t=%0t req=%b gnt=%b idx=%0d valid=%b required gnt=%b holder=%0d",
                         $time, req, gnt, gnt_idx, gnt_valid, e_gnt, m_holder);
            end
        end
    end

    // One clock: apply inputs, then wait until outputs of that edge settle.
    task automatic cyc(input logic [3:0] r);
        req = r;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                       input logic e_valid);
        vectors++;
        if (gnt !== e_gnt || gnt_idx !== e_idx || gnt_valid !== e_valid) begin
            miscompares++;
            $display("FAIL %s gnt=%b idx=%b valid=%b required gnt=%b idx=%b valid=%b",
                     name, gnt, gnt_idx, gnt_valid, e_gnt, e_idx, e_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        rst         = 1'b1;
        req         = 4'b0000;
        @(negedge clk);
        check_en = 1'b1;
        lit("reset", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000);
            lit("idle", 4'b0000, 2'b00, 1'b0);
        end

        // Rotation with all requesting; each holder drops for one cycle.
        cyc(4'b1111); lit("rot0", 4'b0001, 2'd0, 1'b1);
        cyc(4'b1110); lit("rot1", 4'b0010, 2'd1, 1'b1);
        cyc(4'b1101); lit("rot2", 4'b0100, 2'd2, 1'b1);
        cyc(4'b1011); lit("rot3", 4'b1000, 2'd3, 1'b1);
        cyc(4'b0111); lit("rot4", 4'b0001, 2'd0, 1'b1);
        cyc(4'b0000); lit("rot_idle", 4'b0000, 2'b00, 1'b0);

        // Single requester 2 for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100);
            lit("single2", 4'b0100, 2'd2, 1'b1);
        end
        cyc(4'b0000); lit("single2_drop", 4'b0000, 2'b00, 1'b0);

        // Reset in the middle of a grant to requester 1.
        cyc(4'b0010); lit("r1_grant", 4'b0010, 2'd1, 1'b1);
        cyc(4'b0010); lit("r1_hold", 4'b0010, 2'd1, 1'b1);
        rst = 1'b1;
        cyc(4'b0010); lit("mid_reset", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
        cyc(4'b0010); lit("r1_regrant", 4'b0010, 2'd1, 1'b1);
        cyc(4'b0000);

        // Two requesters held constant, starting from fresh priority.
        rst = 1'b1;
        cyc(4'b0000);
        rst = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0011);
            if (i < 4 || i >= 8) lit("timeout_r0", 4'b0001, 2'd0, 1'b1);
            else                 lit("timeout_r1", 4'b0010, 2'd1, 1'b1);
        end
        cyc(4'b0000);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0001);
            lit("timeout_alone", 4'b0001, 2'd0, 1'b1);
        end
`else
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0011);
            lit("unbounded_hold", 4'b0001, 2'd0, 1'b1);
        end
`endif
        cyc(4'b0000);

        // Pseudo-random traffic checked against the model only.
        for (int i = 0; i < 300; i++) begin
            cyc(4'($urandom_range(0, 15)));
        end
        cyc(4'b0000);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one resource between 4 requesters.
- Produces a registered one-hot grant (2-to-4 decoded form) plus the encoded 2-bit winner index.
- Sits in front of the shared datapath. The grant index drives the datapath select; the one-hot grant drives per-requester enables.
- Rotating priority gives fairness. Once a grant is issued, it is held while its request stays high (optionally bounded by a hold limit).

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per requester when others are waiting. Legal range 2..255. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i belongs to requester i; level-sensitive.
- gnt  output  4  registered one-hot grant; all zeros when nothing is granted.
- gnt_idx  output  2  registered encoded index of the current winner; valid only when gnt_valid=1.
- gnt_valid  output  1  registered; high while any gnt bit is high.

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, state=IDLE.
  - last_idx=2'd3, so requester 0 has top priority after reset. hold_cnt=0.
  - Reset overrides everything, including an active grant; gnt drops the edge after rst is sampled.
- Encoding invariant: gnt is always the 2-to-4 decode of gnt_idx (00->0001, 01->0010, 10->0100, 11->1000) when gnt_valid=1, and 0000 otherwise. At most one gnt bit is ever high.
- Priority search: start at (last_idx+1) mod 4 and wrap through all 4 positions; the first set req bit wins. last_idx is updated to the winner on every new grant.
- State IDLE:
  - If req==0, stay IDLE with outputs zero.
  - Otherwise, at the next edge select a winner, load gnt/gnt_idx, set gnt_valid=1, clear hold_cnt, go to GRANT.
  - Latency: req asserted in cycle N -> gnt visible in cycle N+1.
- State GRANT, evaluated each edge using current req:
  - req[gnt_idx]=1 and no forced release: hold the grant; hold_cnt increments.
  - req[gnt_idx]=0 and other requests pending: re-arbitrate in the same edge, with no idle bubble; the new winner's gnt appears the next cycle. The released requester can win again only if it is the sole requester and has re-asserted.
  - req[gnt_idx]=0 and req==0: return to IDLE; gnt=0, gnt_valid=0 next cycle.
  - Requests from other requesters arriving or leaving during a hold do not disturb the current grant.
- Simultaneous requests: resolved purely by rotating priority; no requester may be skipped twice in a row while requesting continuously.
- hold_cnt: 8-bit; cleared on every new grant and on reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt reaches MAX_HOLD-1 while the holder still requests and any other req bit is set, force a release and re-arbitrate at that edge.
  - The holder is excluded from that search (it is last_idx, so it naturally ranks lowest).
  - Forced release happens after exactly MAX_HOLD grant cycles.
  - If no other requester is waiting, keep the grant and reset hold_cnt to 0.
- Not defined: hold_cnt logic is absent; a grant is held until its request drops (unbounded hold).

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0, gnt_idx=00 throughout.
- After reset, req=4'b1111 held; each holder drops its req one cycle after being granted, then re-raises it the following cycle -> grant order 0001, 0010, 0100, 1000, 0001. Each new grant appears the cycle after the previous holder's req drops, with no idle bubble.
- req=4'b0100 for 3 cycles, then 0000 -> gnt=0100, gnt_idx=10 from the cycle after assertion for 3 cycles, then gnt=0000, gnt_valid=0 one cycle after the drop.
- Requester 1 holding, req=4'b0010; assert rst for 1 cycle mid-grant -> gnt=0000 the next cycle. Requester 1 is then re-granted one cycle after rst deasserts (priority restarts from 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held constant -> gnt=0001 for exactly 4 cycles, 0010 for 4 cycles, 0001 again.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0001 only for 10 cycles -> gnt=0001 continuously, never dropped.
